// File: rtl/decoder_stream.sv
// ---------------------------------------------------------------------------
// decoder_stream
//   Flow-controlled N-to-2**N one-hot decoder. Accepted (encode, enable)
//   pairs are buffered in a DEPTH-entry FIFO. The head entry is decoded into
//   a registered output stage with valid/ready handshaking.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   encode     in   N-bit binary index to decode
//   enable     in   sampled with encode; 0 yields an all-zero word
//   in_valid   in   producer presents a pair
//   in_ready   out  FIFO not full (registered state only)
//   decode     out  registered one-hot (or zero) result, 2**N bits
//   out_valid  out  decode holds an unconsumed result
//   out_ready  in   consumer takes decode this cycle
//   count      out  pairs held in the FIFO, output register excluded
// ---------------------------------------------------------------------------
module decoder_stream #(
  parameter int N     = 3,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N-1:0]               encode,
  input  logic                       enable,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [2**N-1:0]            decode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int W  = 2**N;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic         en;
    logic [N-1:0] enc;
  } entry_t;

  entry_t         mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [W-1:0]   decode_q, decode_d;
  logic           out_valid_q, out_valid_d;

  logic           full;
  logic           empty;
  logic           push;
  logic           load;
  entry_t         head;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  // No push while full, even if a pop frees a slot on the same edge.
  assign push  = in_valid && !full;
  // The output register refills whenever it is empty or being consumed.
  assign load  = !empty && (!out_valid_q || out_ready);
  assign head  = mem_q[rd_ptr_q];

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    decode_d    = decode_q;
    out_valid_d = out_valid_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + CW'(push) - CW'(load);

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    if (load) begin
      rd_ptr_d    = rd_ptr_q + AW'(1);
      out_valid_d = 1'b1;
      decode_d    = head.en ? (W'(1) << head.enc) : '0;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      decode_d    = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      decode_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      decode_q    <= decode_d;
      out_valid_q <= out_valid_d;
    end
  end

  // NOTE: FIFO storage has no reset; contents are only read behind count, so stale words never escape.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{en: enable, enc: encode};
    end
  end

  assign in_ready  = !full;
  assign decode    = decode_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;

endmodule

// File: tb/tb_decoder_stream.sv
// ---------------------------------------------------------------------------
// tb_decoder_stream
//   Directed and randomized stimulus for decoder_stream. A queue-based model
//   holds the expected decoded words of buffered pairs plus the expected
//   output register; every cycle the DUT outputs are compared against it.
// ---------------------------------------------------------------------------
module tb_decoder_stream;

  localparam int N     = 3;
  localparam int DEPTH = 4;
  localparam int W     = 2**N;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  encode;
  logic          enable;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  decode;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;

  decoder_stream #(.N(N), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .encode    (encode),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .decode    (decode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: expected decoded words of pairs waiting in the FIFO, in order.
  int  mq[$];
  bit  m_ov;
  int  m_dec;
  bit  accepted;

  // Scoreboard: words expected in acceptance order, words actually consumed.
  int  sb[$];
  int  consumed[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int word_of(input bit en, input int enc);
    return en ? (2 ** enc) : 0;
  endfunction

  task automatic drive(input bit iv, input int enc, input bit en, input bit ordy);
    in_valid  = iv;
    encode    = N'(enc);
    enable    = en;
    out_ready = ordy;
  endtask

  task automatic model_reset();
    mq.delete();
    m_ov  = 1'b0;
    m_dec = 0;
  endtask

  // One clock edge: predict from pre-edge model state and inputs, then compare.
  task automatic tick();
    bit push, load, drain;
    int w;
    if (out_ready && out_valid) consumed.push_back(int'(decode));
    push  = in_valid && (mq.size() < DEPTH);
    load  = (mq.size() > 0) && (!m_ov || out_ready);
    drain = !load && m_ov && out_ready;
    w     = word_of(enable, int'(encode));
    @(posedge clock);
    #1;
    if (load) begin
      m_dec = mq.pop_front();
      m_ov  = 1'b1;
    end else if (drain) begin
      m_dec = 0;
      m_ov  = 1'b0;
    end
    if (push) begin
      mq.push_back(w);
      sb.push_back(w);
    end
    accepted = push;
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("decode",    32'(decode),    32'(m_dec));
    check("count",     32'(count),     32'(mq.size()));
    check("in_ready",  32'(in_ready),  32'(mq.size() != DEPTH));
  endtask

  task automatic idle(input int cycles, input bit ordy);
    for (int i = 0; i < cycles; i++) begin
      drive(1'b0, $urandom_range(0, W - 1), $urandom_range(0, 1), ordy);
      tick();
    end
  endtask

  initial begin
    drive(1'b0, 0, 1'b0, 1'b0);
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_decode",    32'(decode),    32'd0);
    check("rst_count",     32'(count),     32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Single pair, encode=5: visible after the second edge, gone after the third.
    drive(1'b1, 5, 1'b1, 1'b1);
    tick();
    check("lat_not_yet", 32'(out_valid), 32'd0);
    drive(1'b0, 0, 1'b0, 1'b1);
    tick();
    check("lat_decode", 32'(decode), 32'h20);
    check("lat_valid",  32'(out_valid), 32'd1);
    tick();
    check("lat_drained", 32'(out_valid), 32'd0);

    // Back-to-back sweep 0..7 with the consumer always ready.
    consumed.delete();
    for (int i = 0; i < W; i++) begin
      drive(1'b1, i, 1'b1, 1'b1);
      tick();
      check("sweep_count_le1", 32'(count <= 1), 32'd1);
    end
    idle(3, 1'b1);
    check("sweep_len", 32'(consumed.size()), 32'(W));
    for (int i = 0; i < consumed.size() && i < W; i++)
      check("sweep_word", 32'(consumed[i]), 32'(1 << i));

    // enable=0 produces a valid all-zero word.
    drive(1'b1, 3, 1'b0, 1'b1);
    tick();
    drive(1'b0, 0, 1'b1, 1'b1);
    tick();
    check("en0_valid",  32'(out_valid), 32'd1);
    check("en0_decode", 32'(decode),    32'h00);
    idle(2, 1'b1);

    // Back-pressure: fill until full, hold the sixth pair, then release.
    consumed.delete();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, i, 1'b1, 1'b0);
      tick();
    end
    check("full_count",    32'(count),    32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 5, 1'b1, 1'b0);
    tick();
    check("full_held", 32'(accepted), 32'd0);
    drive(1'b1, 5, 1'b1, 1'b1);
    tick();
    check("ready_after_pop", 32'(in_ready), 32'd1);
    check("sixth_not_yet",   32'(accepted), 32'd0);
    tick();
    check("sixth_accepted",  32'(accepted), 32'd1);
    idle(8, 1'b1);
    check("bp_len", 32'(consumed.size()), 32'd6);
    for (int i = 0; i < consumed.size() && i < 6; i++)
      check("bp_word", 32'(consumed[i]), 32'(1 << i));

    // Steady state at count=2 with simultaneous push and pop.
    consumed.delete();
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, i, 1'b1, 1'b0);
      tick();
    end
    check("steady_fill", 32'(count), 32'd2);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, (i + 3) % W, 1'b1, 1'b1);
      tick();
      check("steady_count", 32'(count), 32'd2);
    end
    idle(5, 1'b1);
    check("steady_len", 32'(consumed.size()), 32'(sb.size()));
    for (int i = 0; i < consumed.size() && i < sb.size(); i++)
      check("steady_order", 32'(consumed[i]), 32'(sb[i]));

    // Randomized traffic against the model and the ordering scoreboard.
    consumed.delete();
    sb.delete();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, $urandom_range(0, W - 1), ($urandom % 4) != 0,
            ($urandom % 3) != 0);
      tick();
    end
    idle(8, 1'b1);
    check("rand_len", 32'(consumed.size()), 32'(sb.size()));
    for (int i = 0; i < consumed.size() && i < sb.size(); i++)
      check("rand_order", 32'(consumed[i]), 32'(sb[i]));

    // Reset mid-operation with count=3 and a result waiting.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 7 - i, 1'b1, 1'b0);
      tick();
    end
    check("pre_rst_count", 32'(count),     32'd3);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    drive(1'b0, 0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid",    32'(out_valid), 32'd0);
    check("async_rst_decode",   32'(decode),    32'd0);
    check("async_rst_count",    32'(count),     32'd0);
    check("async_rst_in_ready", 32'(in_ready),  32'd1);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    drive(1'b1, 6, 1'b1, 1'b1);
    tick();
    drive(1'b0, 0, 1'b0, 1'b1);
    tick();
    check("post_rst_decode", 32'(decode),    32'h40);
    check("post_rst_valid",  32'(out_valid), 32'd1);
    tick();
    check("post_rst_empty",  32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_stream.md
Name: decoder_stream

Overview:
- Registered, flow-controlled N-to-2**N one-hot decoder. It is the inverse of the team's priority encoder.
- Accepts (encode, enable) pairs on a valid/ready input and buffers them in a small FIFO.
- Emits one registered one-hot word per accepted pair on a valid/ready output.
- Sits downstream of the encoder so that round-trip encode->decode checks can run under back-pressure.

Parameters:
- N, 3, encoded input width; the output is 2**N bits wide.
- DEPTH, 4, FIFO entries; must be a power of two, >= 2.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- encode  input  N  binary index to decode.
- enable  input  1  sampled with encode; 0 makes the decoded word all-zero.
- in_valid  input  1  producer has a pair on encode/enable.
- in_ready  output  1  block can accept; equals !full.
- decode  output  2**N  registered one-hot result.
- out_valid  output  1  decode holds an unconsumed result.
- out_ready  input  1  consumer takes decode this cycle.
- count  output  $clog2(DEPTH)+1  number of pairs held in the FIFO, excluding the output register.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - decode=0, out_valid=0, count=0, FIFO pointers=0.
  - in_ready=1 while reset is held and after release.
  - FIFO contents are don't-care.
- Push: a pair is written at the rising edge where in_valid && in_ready. encode and enable are stored together as one (N+1)-bit entry.
- in_ready is combinational from registered state only: in_ready = (count != DEPTH).
- No push while full, even if a pop occurs in the same cycle. No fall-through path from input to output.
- Output load: the output register loads when the FIFO is non-empty and (out_valid==0 || out_ready). At that edge:
  - decode <= enable ? (1 << encode) : 0; out_valid <= 1; the head entry is popped.
- Output drain: if out_valid && out_ready and the FIFO is empty, then out_valid <= 0 and decode <= 0.
- Hold: if out_valid && !out_ready, decode and out_valid hold and nothing is popped.
- Latency: a pair pushed into an empty block at edge k appears on decode/out_valid after edge k+1, i.e. 2 cycles from in_valid.
- Throughput: 1 result per cycle when out_ready is held high.
- Simultaneous push and pop in the same edge: count is unchanged, and both the read and write pointers advance.
- count after each edge = count + push - pop.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH without special handling.
- Decode is exactly one-hot (popcount 1) when the stored enable=1, and exactly zero when it was 0. Every encode value 0..2**N-1 is legal; there is no out-of-range case.
- Ordering: outputs leave strictly in acceptance order. Nothing is dropped or duplicated.
- Reset mid-operation: all buffered and in-flight pairs are discarded immediately. out_valid falls asynchronously with reset.
- Inputs are ignored when in_valid=0, whatever the values on encode/enable.

Test Plan:
- Reset, then push encode=5, enable=1 with out_ready=1:
  - decode=8'b0010_0000 and out_valid=1 two cycles after in_valid.
  - out_valid=0 on the following cycle.
- Sweep encode 0..7 with enable=1 back-to-back and out_ready=1:
  - decode = 1,2,4,...,128 on consecutive cycles.
  - count stays <= 1 throughout.
- Push encode=3 with enable=0 -> out_valid=1 and decode=8'h00.
- Hold out_ready=0 and push 6 pairs (0..5):
  - First pair goes to the output register; count rises to 4.
  - in_ready=0 after the 5th accept; the 6th is held by the producer.
  - Then release out_ready=1: outputs are 1,2,4,8,16,32 in order, and in_ready returns to 1 one edge after the first pop.
- Keep the FIFO at count=2 with continuous push and pop for 10 cycles:
  - count stays at 2; pointers wrap.
  - Output sequence matches input sequence.
- Assert reset while count=3 and out_valid=1:
  - decode=0, out_valid=0, count=0 immediately, without waiting for a clock edge.
  - After release, the first new push decodes correctly with no stale data.
